// File: rtl/mem_arbiter_pkg.sv
// Shared types and field widths for the fetch/data memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned WeW   = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWaitI = 2'd1,
    StWaitD = 2'd2
  } arb_state_e;

  // Data has priority unless fetch has been starved for the full allowance.
  function automatic logic fetch_wins(input logic if_req, input logic d_req, input logic starved);
    return if_req && (!d_req || starved);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single memory port with one outstanding
// transaction and bounded fetch starvation.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned AW         = 32
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             if_req,
  input  logic [AW-1:0]    if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [DataW-1:0] if_rdata,

  input  logic             d_req,
  input  logic [WeW-1:0]   d_we,
  input  logic [AW-1:0]    d_addr,
  input  logic [DataW-1:0] d_wdata,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [DataW-1:0] d_rdata,

  output logic             mem_req,
  output logic [WeW-1:0]   mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DataW-1:0] mem_wdata,
  input  logic             mem_ready,
  input  logic             mem_rvalid,
  input  logic [DataW-1:0] mem_rdata
);

  localparam int unsigned CntW =
      ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
  localparam logic [CntW-1:0] StarveLimit = CntW'(STARVE_MAX);

  arb_state_e      state_q, state_d;
  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
  logic            is_store_q, is_store_d;

  logic starved;
  logic pick_fetch;

  assign starved    = (starve_cnt_q == StarveLimit);
  assign pick_fetch = fetch_wins(if_req, d_req, starved);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      starve_cnt_q <= '0;
      is_store_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      is_store_q   <= is_store_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    is_store_d   = is_store_q;

    mem_req   = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;

    // Outputs are forced quiet during reset; the register block handles state.
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          // mem_rvalid seen here is stray and deliberately ignored.
          if (if_req || d_req) begin
            mem_req = 1'b1;
            if (pick_fetch) begin
              mem_addr = if_addr;
              if_gnt   = mem_ready;
              if (mem_ready) begin
                state_d      = StWaitI;
                starve_cnt_d = '0;
              end
            end else begin
              mem_we    = d_we;
              mem_addr  = d_addr;
              mem_wdata = d_wdata;
              d_gnt     = mem_ready;
              if (mem_ready) begin
                state_d    = StWaitD;
                is_store_d = |d_we;
                if (if_req && !starved) begin
                  starve_cnt_d = starve_cnt_q + 1'b1;
                end
              end
            end
          end
        end
        StWaitI: begin
          if (mem_rvalid) begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
            state_d   = StIdle;
          end
        end
        StWaitD: begin
          if (mem_rvalid) begin
            d_rvalid = 1'b1;
            d_rdata  = is_store_q ? '0 : mem_rdata;
            state_d  = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int unsigned StarveMax = 4;
  localparam int unsigned Aw        = 32;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [Aw-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;
  logic          d_req;
  logic [3:0]    d_we;
  logic [Aw-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;
  logic          mem_req;
  logic [3:0]    mem_we;
  logic [Aw-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ready;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;

  mem_arbiter #(
    .STARVE_MAX(StarveMax),
    .AW        (Aw)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: which transaction is outstanding (0 none, 1 fetch, 2 data).
  int m_outstanding = 0;
  bit m_store       = 1'b0;
  int m_starve      = 0;

  // Bench-side request holders and memory responder.
  bit if_pend   = 1'b0;
  bit d_pend    = 1'b0;
  bit busy      = 1'b0;
  int resp_wait = 0;

  // Stimulus knobs.
  bit force_rst  = 1'b0;
  bit force_both = 1'b0;
  int lat_max    = 1;
  int rst_pct    = 0;
  int req_pct    = 50;

  task automatic run_cycle();
    bit          fetch;
    logic        e_mem_req, e_if_gnt, e_d_gnt, e_if_rvalid, e_d_rvalid;
    logic [3:0]  e_we;
    logic [31:0] e_addr, e_wdata, e_if_rdata, e_d_rdata;

    @(negedge clk);
    rst = force_rst || ((rst_pct != 0) && ($urandom_range(99) < rst_pct));
    if (!if_pend && (force_both || $urandom_range(99) < req_pct)) begin
      if_pend = 1'b1;
      if_addr = $urandom & 32'hffff_fffc;
    end
    if (!d_pend && (force_both || $urandom_range(99) < req_pct)) begin
      d_pend  = 1'b1;
      d_we    = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
      d_addr  = $urandom;
      d_wdata = $urandom;
    end
    if_req     = if_pend;
    d_req      = d_pend;
    mem_ready  = busy ? 1'b0 : (force_both ? 1'b1 : ($urandom_range(99) < 75));
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (busy) begin
      if (resp_wait == 1) begin
        mem_rvalid = 1'b1;
        mem_rdata  = $urandom;
      end else begin
        resp_wait--;
      end
    end else if (m_outstanding == 0 && $urandom_range(9) == 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = $urandom;
    end
    #1;

    e_mem_req = 1'b0; e_if_gnt = 1'b0; e_d_gnt = 1'b0;
    e_if_rvalid = 1'b0; e_d_rvalid = 1'b0;
    e_we = '0; e_addr = '0; e_wdata = '0; e_if_rdata = '0; e_d_rdata = '0;
    if (!rst) begin
      if (m_outstanding == 0) begin
        if (if_req || d_req) begin
          fetch     = if_req && (!d_req || m_starve >= StarveMax);
          e_mem_req = 1'b1;
          if (fetch) begin
            e_addr   = if_addr;
            e_if_gnt = mem_ready;
          end else begin
            e_we    = d_we;
            e_addr  = d_addr;
            e_wdata = d_wdata;
            e_d_gnt = mem_ready;
          end
        end
      end else if (mem_rvalid) begin
        if (m_outstanding == 1) begin
          e_if_rvalid = 1'b1;
          e_if_rdata  = mem_rdata;
        end else begin
          e_d_rvalid = 1'b1;
          e_d_rdata  = m_store ? 32'h0 : mem_rdata;
        end
      end
    end

    check("mem_req",   32'(mem_req),   32'(e_mem_req));
    check("mem_we",    32'(mem_we),    32'(e_we));
    check("mem_addr",  mem_addr,       e_addr);
    check("mem_wdata", mem_wdata,      e_wdata);
    check("if_gnt",    32'(if_gnt),    32'(e_if_gnt));
    check("d_gnt",     32'(d_gnt),     32'(e_d_gnt));
    check("if_rvalid", 32'(if_rvalid), 32'(e_if_rvalid));
    check("if_rdata",  if_rdata,       e_if_rdata);
    check("d_rvalid",  32'(d_rvalid),  32'(e_d_rvalid));
    check("d_rdata",   d_rdata,        e_d_rdata);

    @(posedge clk);
    if (rst) begin
      m_outstanding = 0;
      m_starve      = 0;
    end else if (m_outstanding == 0) begin
      if (e_if_gnt) begin
        m_outstanding = 1;
        m_starve      = 0;
      end else if (e_d_gnt) begin
        m_outstanding = 2;
        m_store       = (d_we != 4'h0);
        if (if_req && m_starve < StarveMax) m_starve++;
      end
    end else if (mem_rvalid) begin
      m_outstanding = 0;
    end

    // The memory keeps its response even across reset; it then arrives in IDLE.
    if (busy && mem_rvalid) busy = 1'b0;
    if (e_if_gnt) if_pend = 1'b0;
    if (e_d_gnt)  d_pend  = 1'b0;
    if (e_if_gnt || e_d_gnt) begin
      busy      = 1'b1;
      resp_wait = $urandom_range(lat_max, 1);
    end
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = '0;
    d_addr = '0; d_wdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset with requests pending: everything must stay quiet.
    force_rst  = 1'b1;
    force_both = 1'b1;
    repeat (3) run_cycle();
    force_rst = 1'b0;

    // Both ports saturated at single-cycle latency: 4 data grants per fetch.
    lat_max = 1;
    repeat (60) run_cycle();

    // Saturated with longer latencies.
    lat_max = 4;
    repeat (60) run_cycle();

    // Fully random traffic, stray responses, and mid-transaction resets.
    force_both = 1'b0;
    rst_pct    = 2;
    req_pct    = 40;
    repeat (1500) run_cycle();

    // Heavy load with random reset to exercise starvation near the limit.
    req_pct = 90;
    lat_max = 2;
    repeat (600) run_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
